// File: rtl/afe_line_scheduler.sv
// afe_line_scheduler
//   Frame-level sequencer for the AFE readout controller and the TFT panel
//   gate driver. A host start edge arms a frame: GATE_STV is pulsed, then one
//   SAMPLE_EN pulse (one AFE integrate/shift cycle) and one GATE_CPV pulse
//   are issued per panel line at the latched line period.
//
// Ports
//   CLK_100M     system clock
//   CLK_RST      asynchronous active-high reset
//   ADS_INIT_OK  ADC initialisation complete (level); low aborts a frame
//   FRAME_START  rising edge requests a frame
//   FRAME_ABORT  level; terminates the frame in progress, blocks starts
//   CONT_MODE    1 = restart automatically after FRAME_DONE
//   LINE_PERIOD  cycles per line, latched at frame accept
//   LINE_NUM     lines per frame, latched at frame accept
//   SAMPLE_EN    to AFE controller; rising edge starts one line sample
//   GATE_STV     gate driver frame start
//   GATE_CPV     gate driver line shift clock
//   LINE_IDX     current line, 0-based
//   FRAME_BUSY   high from ARM through DONE
//   FRAME_DONE   one-cycle pulse at normal frame end
//   CFG_ERR      one-cycle pulse when a start is rejected
module afe_line_scheduler #(
  parameter int unsigned MIN_LINE_PERIOD = 6600,
  parameter int unsigned SAMPLE_HI       = 20,
  parameter int unsigned STV_CYC         = 100,
  parameter int unsigned CPV_OFS         = 10,
  parameter int unsigned CPV_CYC         = 50
) (
  input  logic        CLK_100M,
  input  logic        CLK_RST,
  input  logic        ADS_INIT_OK,
  input  logic        FRAME_START,
  input  logic        FRAME_ABORT,
  input  logic        CONT_MODE,
  input  logic [15:0] LINE_PERIOD,
  input  logic [11:0] LINE_NUM,
  output logic        SAMPLE_EN,
  output logic        GATE_STV,
  output logic        GATE_CPV,
  output logic [11:0] LINE_IDX,
  output logic        FRAME_BUSY,
  output logic        FRAME_DONE,
  output logic        CFG_ERR
);

  localparam logic [15:0] MIN_PERIOD = 16'(MIN_LINE_PERIOD);
  localparam logic [15:0] SAMPLE_END = 16'(SAMPLE_HI);
  localparam logic [15:0] STV_LAST   = 16'(STV_CYC - 1);
  localparam logic [15:0] CPV_BEGIN  = 16'(CPV_OFS);
  localparam logic [15:0] CPV_END    = 16'(CPV_OFS + CPV_CYC);

  typedef enum logic [1:0] {IDLE, ARM, LINE, DONE} state_t;

  state_t      state, state_n;
  logic        start_r;
  // p counts STV cycles in ARM and the position within a line in LINE
  logic [15:0] p, p_n;
  logic [11:0] idx_n;
  logic [15:0] period_q, period_n;
  logic [11:0] num_q, num_n;
  logic        cont_q, cont_n;
  logic        cfg_err_n;
  logic        start_edge;
  logic        abort;
  logic        cfg_ok;

  assign start_edge = FRAME_START & ~start_r;
  assign abort      = FRAME_ABORT | ~ADS_INIT_OK;
  assign cfg_ok     = (LINE_PERIOD >= MIN_PERIOD) && (LINE_NUM != 12'd0);

  always_comb begin
    state_n   = state;
    p_n       = p;
    idx_n     = LINE_IDX;
    period_n  = period_q;
    num_n     = num_q;
    cont_n    = cont_q;
    cfg_err_n = 1'b0;
    case (state)
      IDLE: begin
        // A held FRAME_ABORT masks the edge entirely, so no CFG_ERR either
        if (start_edge && ADS_INIT_OK && !FRAME_ABORT) begin
          if (cfg_ok) begin
            state_n  = ARM;
            p_n      = 16'd0;
            idx_n    = 12'd0;
            period_n = LINE_PERIOD;
            num_n    = LINE_NUM;
            cont_n   = CONT_MODE;
          end else begin
            cfg_err_n = 1'b1;
          end
        end
      end
      ARM: begin
        if (abort) begin
          state_n = IDLE;
          p_n     = 16'd0;
          idx_n   = 12'd0;
        end else if (p == STV_LAST) begin
          state_n = LINE;
          p_n     = 16'd0;
        end else begin
          p_n = p + 16'd1;
        end
      end
      LINE: begin
        if (abort) begin
          state_n = IDLE;
          p_n     = 16'd0;
          idx_n   = 12'd0;
        end else if (p == period_q - 16'd1) begin
          if (LINE_IDX == num_q - 12'd1) begin
            state_n = DONE;
          end else begin
            idx_n = LINE_IDX + 12'd1;
            p_n   = 16'd0;
          end
        end else begin
          p_n = p + 16'd1;
        end
      end
      DONE: begin
        if (abort) begin
          state_n = IDLE;
          p_n     = 16'd0;
          idx_n   = 12'd0;
        end else if (cont_q && cfg_ok) begin
          // Auto-restart re-latches the live config, exactly like a host start
          state_n  = ARM;
          p_n      = 16'd0;
          idx_n    = 12'd0;
          period_n = LINE_PERIOD;
          num_n    = LINE_NUM;
          cont_n   = CONT_MODE;
        end else begin
          state_n   = IDLE;
          p_n       = 16'd0;
          cfg_err_n = cont_q;
        end
      end
      default: begin
        state_n = IDLE;
        p_n     = 16'd0;
      end
    endcase
  end

  // Outputs are decoded from the next-state values so every output is a flop
  always_ff @(posedge CLK_100M or posedge CLK_RST) begin
    if (CLK_RST) begin
      state      <= IDLE;
      start_r    <= 1'b0;
      p          <= 16'd0;
      period_q   <= 16'd0;
      num_q      <= 12'd0;
      cont_q     <= 1'b0;
      LINE_IDX   <= 12'd0;
      SAMPLE_EN  <= 1'b0;
      GATE_STV   <= 1'b0;
      GATE_CPV   <= 1'b0;
      FRAME_BUSY <= 1'b0;
      FRAME_DONE <= 1'b0;
      CFG_ERR    <= 1'b0;
    end else begin
      state      <= state_n;
      start_r    <= FRAME_START;
      p          <= p_n;
      period_q   <= period_n;
      num_q      <= num_n;
      cont_q     <= cont_n;
      LINE_IDX   <= idx_n;
      SAMPLE_EN  <= (state_n == LINE) && (p_n < SAMPLE_END);
      GATE_STV   <= (state_n == ARM);
      GATE_CPV   <= (state_n == LINE) && (p_n >= CPV_BEGIN) && (p_n < CPV_END);
      FRAME_BUSY <= (state_n != IDLE);
      FRAME_DONE <= (state_n == DONE);
      CFG_ERR    <= cfg_err_n;
    end
  end

endmodule

// File: tb/tb_afe_line_scheduler.sv
// Bench for afe_line_scheduler: directed scenarios plus a randomized phase,
// each cycle compared against a timeline model that derives every output
// from the number of cycles elapsed since the frame was accepted.
module tb_afe_line_scheduler;

  logic        CLK_100M    = 1'b0;
  logic        CLK_RST     = 1'b1;
  logic        ADS_INIT_OK = 1'b0;
  logic        FRAME_START = 1'b0;
  logic        FRAME_ABORT = 1'b0;
  logic        CONT_MODE   = 1'b0;
  logic [15:0] LINE_PERIOD = 16'd0;
  logic [11:0] LINE_NUM    = 12'd0;
  logic        SAMPLE_EN;
  logic        GATE_STV;
  logic        GATE_CPV;
  logic [11:0] LINE_IDX;
  logic        FRAME_BUSY;
  logic        FRAME_DONE;
  logic        CFG_ERR;

  always #5 CLK_100M = ~CLK_100M;

  afe_line_scheduler dut (
    .CLK_100M    (CLK_100M),
    .CLK_RST     (CLK_RST),
    .ADS_INIT_OK (ADS_INIT_OK),
    .FRAME_START (FRAME_START),
    .FRAME_ABORT (FRAME_ABORT),
    .CONT_MODE   (CONT_MODE),
    .LINE_PERIOD (LINE_PERIOD),
    .LINE_NUM    (LINE_NUM),
    .SAMPLE_EN   (SAMPLE_EN),
    .GATE_STV    (GATE_STV),
    .GATE_CPV    (GATE_CPV),
    .LINE_IDX    (LINE_IDX),
    .FRAME_BUSY  (FRAME_BUSY),
    .FRAME_DONE  (FRAME_DONE),
    .CFG_ERR     (CFG_ERR)
  );

  logic [17:0] outs;
  assign outs = {SAMPLE_EN, GATE_STV, GATE_CPV, FRAME_BUSY, FRAME_DONE, CFG_ERR, LINE_IDX};

  int    n_vec = 0;
  int    n_err = 0;
  string phase = "reset";

  // Reference model: a frame is a timeline starting at t=1 (first STV cycle).
  // STV covers t=1..100, line L offset o sits at t=101+L*P+o, DONE at t=101+N*P.
  bit m_act, m_start_r, m_err, m_cont;
  int m_t, m_p, m_n, m_idx_idle;

  task automatic chk_eq(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_cfg_ok();
    return (int'(LINE_PERIOD) >= 6600) && (LINE_NUM != 12'd0);
  endfunction

  function automatic void m_accept();
    m_act  = 1'b1;
    m_t    = 1;
    m_p    = int'(LINE_PERIOD);
    m_n    = int'(LINE_NUM);
    m_cont = CONT_MODE;
  endfunction

  function automatic void m_reset();
    m_act = 0; m_start_r = 0; m_err = 0; m_cont = 0;
    m_t = 0; m_p = 0; m_n = 0; m_idx_idle = 0;
  endfunction

  function automatic void m_step();
    bit edge_seen;
    if (CLK_RST) begin
      m_reset();
      return;
    end
    edge_seen = FRAME_START && !m_start_r;
    m_start_r = FRAME_START;
    m_err     = 1'b0;
    if (m_act) begin
      if (FRAME_ABORT || !ADS_INIT_OK) begin
        m_act      = 1'b0;
        m_idx_idle = 0;
      end else if (m_t == 101 + m_n * m_p) begin
        m_act      = 1'b0;
        m_idx_idle = m_n - 1;
        if (m_cont) begin
          if (m_cfg_ok()) m_accept();
          else m_err = 1'b1;
        end
      end else begin
        m_t++;
      end
    end else if (edge_seen && ADS_INIT_OK && !FRAME_ABORT) begin
      if (m_cfg_ok()) m_accept();
      else m_err = 1'b1;
    end
  endfunction

  function automatic logic [17:0] m_vec();
    logic s, stv, cpv, busy, done;
    int idx, l, o;
    s = 0; stv = 0; cpv = 0; busy = 0; done = 0; idx = m_idx_idle;
    if (m_act) begin
      busy = 1;
      if (m_t <= 100) begin
        stv = 1;
        idx = 0;
      end else if (m_t == 101 + m_n * m_p) begin
        done = 1;
        idx  = m_n - 1;
      end else begin
        l   = (m_t - 101) / m_p;
        o   = (m_t - 101) % m_p;
        idx = l;
        s   = (o < 20);
        cpv = (o >= 10) && (o < 60);
      end
    end
    return {s, stv, cpv, busy, done, m_err, 12'(idx)};
  endfunction

  task automatic tick();
    @(posedge CLK_100M);
    m_step();
    @(negedge CLK_100M);
    chk_eq(phase, outs, m_vec());
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    FRAME_START = 1'b1;
    tick();
    FRAME_START = 1'b0;
    tick();
  endtask

  task automatic run_until_idle(input int max_cyc);
    int n;
    n = 0;
    while (FRAME_BUSY && n < max_cyc) begin
      tick();
      n++;
    end
    chk_eq({phase, "_end"}, {17'd0, FRAME_BUSY}, 18'd0);
  endtask

  task automatic wait_t(input int target, input int max_cyc);
    int n;
    n = 0;
    while (m_act && m_t != target && n < max_cyc) begin
      tick();
      n++;
    end
  endtask

  initial begin
    m_reset();
    ticks(3);
    chk_eq("reset_state", outs, 18'd0);
    CLK_RST     = 1'b0;
    ADS_INIT_OK = 1'b1;
    LINE_PERIOD = 16'd6600;
    LINE_NUM    = 12'd3;
    ticks(2);

    phase = "basic";
    pulse_start();
    run_until_idle(25000);
    ticks(3);

    phase = "cfg_p6599";
    LINE_PERIOD = 16'd6599;
    pulse_start();
    ticks(3);
    phase = "cfg_n0";
    LINE_PERIOD = 16'd6600;
    LINE_NUM    = 12'd0;
    pulse_start();
    ticks(3);

    phase = "idle_abort";
    LINE_NUM    = 12'd3;
    FRAME_ABORT = 1'b1;
    pulse_start();
    FRAME_ABORT = 1'b0;
    ticks(3);

    phase = "cont";
    LINE_NUM  = 12'd2;
    CONT_MODE = 1'b1;
    pulse_start();
    ticks(500);
    CONT_MODE = 1'b0;
    run_until_idle(30000);
    ticks(3);

    phase = "abort";
    pulse_start();
    wait_t(101 + 6600 + 10, 10000);
    FRAME_ABORT = 1'b1;
    ticks(3);
    FRAME_ABORT = 1'b0;
    ticks(2);

    phase = "post_abort";
    LINE_NUM = 12'd1;
    pulse_start();
    ticks(300);
    FRAME_START = 1'b1;
    tick();
    run_until_idle(10000);
    ticks(5);
    FRAME_START = 1'b0;
    ticks(3);

    phase = "ads_drop";
    pulse_start();
    ticks(50);
    ADS_INIT_OK = 1'b0;
    ticks(3);
    phase = "ads_low_start";
    pulse_start();
    ticks(3);
    ADS_INIT_OK = 1'b1;
    ticks(2);

    phase = "async_rst";
    pulse_start();
    ticks(300);
    CLK_RST = 1'b1;
    #1;
    chk_eq("async_rst_now", outs, 18'd0);
    ticks(2);
    CLK_RST = 1'b0;
    ticks(2);

    phase = "random";
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 39) == 0) FRAME_START = ~FRAME_START;
      FRAME_ABORT = ($urandom_range(0, 2999) == 0);
      ADS_INIT_OK = ($urandom_range(0, 2999) != 0);
      if ($urandom_range(0, 199) == 0) begin
        LINE_PERIOD = 16'(6595 + $urandom_range(0, 10));
        LINE_NUM    = 12'($urandom_range(0, 2));
        CONT_MODE   = 1'($urandom_range(0, 1));
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
